crc32_stream: RTL

- Parametrised Ethernet CRC-32 engine for streaming frames; processes P_DATA_W/8 bytes per beat.
- Accepts a valid/ready stream with byte keep and last markers.
- Per frame, returns one status record holding the computed FCS, a residue-check pass flag and the frame byte count, over a valid/ready status handshake.
- Sits between the MII/RGMII byte assembler and the MAC rx/tx framers; serves both FCS generation (tx) and FCS checking (rx).

---
 rtl/crc32_stream_if.sv | 27 ++
 rtl/crc32_stream.sv | 105 ++++++++++
 2 files changed

// File: rtl/crc32_stream_if.sv
// Beat stream and status record bundle for the CRC-32 engine.
// master drives beats and consumes status; slave is the engine.
interface crc32_stream_if #(
    parameter int P_DATA_W = 32,
    parameter int P_CNT_W  = 16
);
    logic [P_DATA_W-1:0]   s_data;
    logic [P_DATA_W/8-1:0] s_keep;
    logic                  s_last;
    logic                  s_valid;
    logic                  s_ready;
    logic [31:0]           st_fcs;
    logic                  st_ok;
    logic [P_CNT_W-1:0]    st_len;
    logic                  st_valid;
    logic                  st_ready;

    modport master (
        output s_data, s_keep, s_last, s_valid, st_ready,
        input  s_ready, st_fcs, st_ok, st_len, st_valid
    );

    modport slave (
        input  s_data, s_keep, s_last, s_valid, st_ready,
        output s_ready, st_fcs, st_ok, st_len, st_valid
    );
endinterface

// File: rtl/crc32_stream.sv
// Streaming Ethernet CRC-32 engine: FCS generation and residue check.
// One status record per frame over a single-slot valid/ready handshake.
module crc32_stream #(
    parameter int          P_DATA_W  = 32,
    parameter logic [31:0] P_RESIDUE = 32'hC704DD7B,
    parameter int          P_CNT_W   = 16
) (
    input logic           clk,
    input logic           rst_n,
    crc32_stream_if.slave bus
);
    localparam int          NB   = P_DATA_W / 8;
    localparam logic [31:0] POLY = 32'h04C11DB7;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    logic [1:0]         state;
    logic [31:0]        crc;
    logic [P_CNT_W-1:0] cnt;
    logic [31:0]        fcs_q;
    logic               ok_q;
    logic [P_CNT_W-1:0] len_q;
    logic               valid_q;

    logic [31:0]        crc_nxt;
    logic [3:0]         nbytes;
    logic [P_CNT_W:0]   sum;
    logic [P_CNT_W-1:0] cnt_nxt;
    logic               run;
    logic               rdy;

    // Feeding byte bit 0 first equals bit-reversing it into an MSB-first register.
    function automatic logic [31:0] crc_byte(input logic [31:0] c,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[31] ^ b[i]) r = {r[30:0], 1'b0} ^ POLY;
            else              r = {r[30:0], 1'b0};
        end
        return r;
    endfunction

    function automatic logic [31:0] rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    // Keep only matters on the last beat; the first zero stops the chain.
    always_comb begin
        crc_nxt = crc;
        nbytes  = '0;
        run     = 1'b1;
        for (int k = 0; k < NB; k++) begin
            run = run & (~bus.s_last | bus.s_keep[k]);
            if (run) begin
                crc_nxt = crc_byte(crc_nxt, bus.s_data[8*k +: 8]);
                nbytes  = nbytes + 4'd1;
            end
        end
        sum     = {1'b0, cnt} + {{(P_CNT_W-3){1'b0}}, nbytes};
        cnt_nxt = sum[P_CNT_W] ? {P_CNT_W{1'b1}} : sum[P_CNT_W-1:0];
    end

    assign rdy          = (state != HOLD);
    assign bus.s_ready  = rdy;
    assign bus.st_fcs   = fcs_q;
    assign bus.st_ok    = ok_q;
    assign bus.st_len   = len_q;
    assign bus.st_valid = valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            crc     <= 32'hFFFFFFFF;
            cnt     <= '0;
            fcs_q   <= '0;
            ok_q    <= 1'b0;
            len_q   <= '0;
            valid_q <= 1'b0;
        end else if (state == HOLD) begin
            if (bus.st_ready) begin
                valid_q <= 1'b0;
                state   <= IDLE;
            end
        end else if (bus.s_valid) begin
            if (bus.s_last) begin
                fcs_q   <= rev32(~crc_nxt);
                ok_q    <= (crc_nxt == P_RESIDUE);
                len_q   <= cnt_nxt;
                valid_q <= 1'b1;
                crc     <= 32'hFFFFFFFF;
                cnt     <= '0;
                state   <= HOLD;
            end else begin
                crc     <= crc_nxt;
                cnt     <= cnt_nxt;
                state   <= ACCUM;
            end
        end
    end
endmodule
